// File: rtl/pe_array_sequencer_pkg.sv
// Shared constants, FSM state encoding and vector types for the PE array sequencer.
package pe_pkg;

    localparam int unsigned ARR   = 32'd8;
    localparam int unsigned H     = 32'd8;
    localparam int unsigned BIT   = 32'd8;
    localparam int unsigned ACC   = BIT * 32'd4;
    localparam int unsigned CNT_W = 32'd8;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-32'd1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } seq_state_e;

    typedef logic [ARR-1:0][BIT-1:0]   act_vec_t;
    typedef logic [ARR*H-1:0][BIT-1:0] wgt_vec_t;
    typedef logic [H-1:0][ACC-1:0]     psum_vec_t;

endpackage

// File: rtl/pe_array_sequencer_if.sv
// Tile fetch and job result valid/ready ports of the PE array sequencer.
interface pe_array_sequencer_if import pe_pkg::*; ();

    logic      in_valid;
    logic      in_ready;
    act_vec_t  in_act;
    wgt_vec_t  in_wgt;
    logic      out_valid;
    logic      out_ready;
    psum_vec_t out_data;

    modport master (
        output in_valid, in_act, in_wgt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_act, in_wgt, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/pe_array_sequencer_tile_reg.sv
// Enable-loaded holding registers for the activations and weights presented to the array.
module tile_reg import pe_pkg::*; (
    input  logic     clk,
    input  logic     rst,
    input  logic     load_en,
    input  act_vec_t act_d,
    input  wgt_vec_t wgt_d,
    output act_vec_t act_q,
    output wgt_vec_t wgt_q
);

    // Capture one tile on load_en; hold it for the whole array computation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q <= '0;
            wgt_q <= '0;
        end else if (load_en) begin
            act_q <= act_d;
            wgt_q <= wgt_d;
        end
    end

endmodule

// File: rtl/pe_array_sequencer.sv
// Sequences a multi-tile job through the PE array, feeding each result back as the next bias.
module pe_array_sequencer import pe_pkg::*; (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_tiles,
    input  psum_vec_t            bias_in,
    output logic                 busy,
    pe_array_sequencer_if.slave  io,
    output logic                 arr_en,
    output act_vec_t             arr_ifmap,
    output wgt_vec_t             arr_weight,
    output psum_vec_t            arr_bias,
    input  psum_vec_t            arr_ofmap,
    input  logic                 arr_valid,
    output logic                 err_spurious
);

    seq_state_e       state_r;
    seq_state_e       state_next_s;
    psum_vec_t        acc_r;
    logic [CNT_W-1:0] n_r;
    logic [CNT_W-1:0] tile_cnt_r;
    logic             err_r;
    logic             load_en_s;
    logic             start_acc_s;
    logic             tile_done_s;

    assign start_acc_s = (state_r == S_IDLE) && start;
    assign tile_done_s = (state_r == S_WAIT) && arr_valid;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and tile load strobe.
    always_comb begin
        state_next_s = state_r;
        load_en_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = (num_tiles == '0) ? S_DONE : S_LOAD;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (io.in_valid) begin
                    load_en_s    = 1'b1;
                    state_next_s = S_ISSUE;
                end else begin
                    state_next_s = S_LOAD;
                end
            end
            S_ISSUE: begin
                state_next_s = S_WAIT;
            end
            S_WAIT: begin
                if (arr_valid) begin
                    state_next_s = (tile_cnt_r == n_r - CNT_ONE) ? S_DONE : S_LOAD;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_DONE: begin
                if (io.out_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Accumulator, job length and tile counter; the array result replaces acc each tile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r      <= '0;
            n_r        <= '0;
            tile_cnt_r <= '0;
        end else if (start_acc_s) begin
            acc_r      <= bias_in;
            n_r        <= num_tiles;
            tile_cnt_r <= '0;
        end else if (tile_done_s) begin
            acc_r      <= arr_ofmap;
            tile_cnt_r <= tile_cnt_r + CNT_ONE;
        end
    end

    // Sticky spurious-result flag; a stray result in the accepting cycle still wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (arr_valid && (state_r != S_WAIT)) begin
            err_r <= 1'b1;
        end else if (start_acc_s) begin
            err_r <= 1'b0;
        end
    end

    tile_reg u_tile_reg (
        .clk     (clk),
        .rst     (rst),
        .load_en (load_en_s),
        .act_d   (io.in_act),
        .wgt_d   (io.in_wgt),
        .act_q   (arr_ifmap),
        .wgt_q   (arr_weight)
    );

    assign busy         = (state_r != S_IDLE);
    assign io.in_ready  = (state_r == S_LOAD);
    assign arr_en       = (state_r == S_ISSUE);
    assign io.out_valid = (state_r == S_DONE);
    assign io.out_data  = acc_r;
    assign arr_bias     = acc_r;
    assign err_spurious = err_r;

endmodule

// File: doc/pe_array_sequencer.md
# pe_array_sequencer

Control-side counterpart of the 8x8 int8 PE array. It accepts a job of N input-channel tiles, fetches each tile's activations and weights through a valid/ready port, and drives the array one tile at a time. Each array result is fed back as the next tile's bias, so partial sums accumulate without an external adder. The final 8 x 32-bit output-channel sums are returned on a valid/ready result port. It sits between the tile buffers/DMA and the PE array inside the int8 top.

## Interface
- `ARR`, 8: ifmap lanes per tile (PE blocks in the array)
- `H`, 8: output channels (PE block height)
- `BIT`, 8: activation/weight width
- `ACC`, 32: partial-sum width (`BIT*4`)
- `CNT_W`, 8: tile-count width

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: job request; sampled only in IDLE
- `num_tiles` in `CNT_W`: tiles in the job; sampled with `start`
- `bias_in` in `H`x`ACC`: initial per-channel bias; sampled with `start`
- `busy` out 1: high whenever the state is not IDLE
- `in_valid` in 1: tile data valid
- `in_ready` out 1: sequencer can take a tile
- `in_act` in `ARR`x`BIT`: tile activations
- `in_wgt` in `ARR*H`x`BIT`: tile weights, block-major (entry `k*H+h` = block k, channel h)
- `arr_en` out 1: one-cycle start pulse to the array
- `arr_ifmap` out `ARR`x`BIT`: registered activations to the array
- `arr_weight` out `ARR*H`x`BIT`: registered weights to the array
- `arr_bias` out `H`x`ACC`: accumulator contents, driven to the array bias
- `arr_ofmap` in `H`x`ACC`: array result
- `arr_valid` in 1: array result valid, one-cycle pulse
- `out_valid` out 1: job result valid
- `out_ready` in 1: consumer accepts the result
- `out_data` out `H`x`ACC`: final sums (equals the accumulator)
- `err_spurious` out 1: sticky flag; set when `arr_valid` arrives outside WAIT; cleared by reset or by an accepted `start`

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- **IDLE**
  - On `start=1`: `acc<=bias_in`, `n<=num_tiles`, `tile_cnt<=0`.
  - Go to DONE if `num_tiles==0`, otherwise go to LOAD.
- **LOAD**
  - `in_ready=1`.
  - On `in_valid&in_ready`: capture `in_act`/`in_wgt` into the `arr_ifmap`/`arr_weight` registers, then go to ISSUE.
- **ISSUE**
  - `arr_en=1` for exactly one cycle, then go to WAIT.
- **WAIT**
  - Array inputs are held stable.
  - On `arr_valid`: `acc<=arr_ofmap` and `tile_cnt<=tile_cnt+1`.
  - Go to DONE if `tile_cnt==n-1`, otherwise go to LOAD.
- **DONE**
  - `out_valid=1`, with `out_data=acc` held.
  - On `out_ready`: go to IDLE.
- Arithmetic: the accumulator is fed as `arr_bias`, so `acc_final = bias + sum over tiles`. Addition is two's complement mod 2^`ACC`; there is no saturation.
- Only one tile is ever in flight. The next tile is fetched only after the previous `arr_valid`.
- `start` while `busy` is ignored. `in_valid` outside LOAD is ignored.
- `arr_valid` outside WAIT: no state change, `err_spurious<=1`.
- Reset mid-job: immediate return to IDLE. `acc`, `arr_ifmap`, `arr_weight` and all outputs go to 0, and the job is dropped.

## Timing
- Reset values: `busy`, `in_ready`, `arr_en`, `out_valid` and `err_spurious` are all 0; all data outputs are 0.
- All outputs are registered or decoded from the state register. No combinational path runs from inputs to outputs.
- Cycle sequence:
  - `start` accepted at cycle t; `in_ready` high from t+1.
  - Tile handshake at cycle u; `arr_en` high at u+1.
  - `arr_valid` at cycle v; `in_ready` high again at v+1, or `out_valid` high at v+1 on the last tile.
- Per-tile overhead: 2 cycles plus the array latency, plus the input wait.
- `num_tiles==0`: `out_valid` at t+1 with `out_data=bias_in`.
- `out_valid` stays high until `out_ready`. A new `start` is sampled no earlier than the cycle after the return to IDLE.

## Structure
- Shared package `pe_pkg`:
  - constants `ARR`, `H`, `BIT`, `ACC`
  - state enum `seq_state_e`
  - typedefs `act_vec_t`, `wgt_vec_t`, `psum_vec_t`
- The FSM and counter are in a single module.
- A natural sub-module is `tile_reg`, the enable-loaded register bank for `arr_ifmap`/`arr_weight` with async clear. It is instantiated once.

## Test plan
- **Single tile:** bias all 5, act all 1, weight all 2, array model returns bias+16 per channel → `out_data` all 21; `arr_en` exactly one pulse.
- **Three tiles:** bias 0, act[k]=k+1, weight all 1 → per tile +36, final `out_data` all 108; `arr_bias` equals the running sum 0, 36, 72 at each ISSUE.
- **`num_tiles=0`:** bias_in = 0..7 → `out_valid` the cycle after `start`, `out_data` = 0..7, `arr_en` never asserted.
- **Backpressure:** `in_valid` delayed 4 cycles, `out_ready` low for 5 cycles → `in_ready` held, `out_data` stable, no extra `arr_en`.
- **Wrap and errors:** bias 0x7FFFFFFF plus a tile adding 1 → 0x80000000; `arr_valid` injected in LOAD → `err_spurious=1`, state unchanged; `start` while busy → ignored.
- **Reset mid-WAIT:** `rst` low in WAIT → `busy`/`arr_en`/`out_valid` go to 0 immediately; after release, a new single-tile job completes correctly.
